cc_miss_req_ctrl: RTL and testbench

- Sequences cache-line refills between the cache miss path and the AXI memory read channels.
- Accepts one miss at a time and pushes the miss address into the miss-address FIFO, which the data fill unit drains.
- Issues a critical-word-first WRAP read burst on the AR channel.
- Counts outstanding refills by watching R-channel last beats, and throttles new misses at a programmable depth.

---
 rtl/cc_miss_req_ctrl.sv | 118 +++++++++++
 tb/tb_cc_miss_req_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_miss_req_ctrl.sv
// rtl/cc_miss_req_ctrl.sv - miss-to-AXI-AR refill sequencer with outstanding-refill throttle
// Optional R-burst protocol checker enabled by CC_MISS_RD_ERR_CHK_EN.
module cc_miss_req_ctrl #(
    parameter int MAX_OUTST   = 2,
    parameter int BURST_BEATS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_req_i,
    input  logic [31:0] miss_addr_i,
    output logic        miss_req_ready_o,
    input  logic        miss_addr_fifo_full_i,
    output logic        miss_addr_fifo_wren_o,
    output logic [31:0] miss_addr_fifo_wdata_o,
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,
    input  logic        mem_rvalid_i,
    input  logic        mem_rready_i,
    input  logic        mem_rlast_i,
    output logic [2:0]  outst_cnt_o,
    output logic        rd_err_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] outst_cnt;
    logic       accept;
    logic       ar_hs;
    logic       r_last_hs;

    assign mem_arlen_o   = 4'(BURST_BEATS - 1);
    assign mem_arsize_o  = 3'b011;
    assign mem_arburst_o = 2'b10;
    assign outst_cnt_o   = outst_cnt;

    assign miss_req_ready_o = (state == IDLE) & (outst_cnt < 3'(MAX_OUTST))
                            & ~miss_addr_fifo_full_i & ~rst;
    assign accept           = miss_req_i & miss_req_ready_o;
    assign ar_hs            = mem_arvalid_o & mem_arready_i;
    assign r_last_hs        = mem_rvalid_i & mem_rready_i & mem_rlast_i;

    // The fill unit needs the full byte address (offset bits) so push it untouched.
    assign miss_addr_fifo_wren_o  = accept;
    assign miss_addr_fifo_wdata_o = accept ? miss_addr_i : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (ar_hs)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_arvalid_o <= 1'b0;
            mem_araddr_o  <= 32'd0;
            outst_cnt     <= 3'd0;
        end else begin
            if (accept) begin
                mem_arvalid_o <= 1'b1;
                mem_araddr_o  <= {miss_addr_i[31:3], 3'b000};
            end else if (ar_hs) begin
                mem_arvalid_o <= 1'b0;
            end
            // An accept and a retiring last beat in the same cycle cancel out.
            case ({accept, r_last_hs})
                2'b10:   outst_cnt <= outst_cnt + 3'd1;
                2'b01:   if (outst_cnt != 3'd0) outst_cnt <= outst_cnt - 3'd1;
                default: outst_cnt <= outst_cnt;
            endcase
        end
    end

`ifdef CC_MISS_RD_ERR_CHK_EN
    localparam logic [2:0] LAST_BEAT = 3'(BURST_BEATS - 1);

    logic [2:0] beat_cnt;
    logic       r_hs;
    logic       err_hit;

    assign r_hs    = mem_rvalid_i & mem_rready_i;
    assign err_hit = r_hs & ((mem_rlast_i & (beat_cnt != LAST_BEAT))
                           | (~mem_rlast_i & (beat_cnt == LAST_BEAT))
                           | (outst_cnt == 3'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= 3'd0;
            rd_err_o <= 1'b0;
        end else begin
            if (r_hs) beat_cnt <= mem_rlast_i ? 3'd0 : beat_cnt + 3'd1;
            if (err_hit) rd_err_o <= 1'b1;
        end
    end
`else
    assign rd_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cc_miss_req_ctrl.sv
// tb/tb_cc_miss_req_ctrl.sv - self-checking bench for cc_miss_req_ctrl
module tb_cc_miss_req_ctrl;
    localparam int MAX_OUTST = 2;
`ifdef CC_MISS_RD_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        ready;
    logic        full;
    logic        wren;
    logic [31:0] wdata;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [2:0]  outst;
    logic        rd_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cc_miss_req_ctrl #(.MAX_OUTST(MAX_OUTST), .BURST_BEATS(8)) dut (
        .clk(clk), .rst(rst),
        .miss_req_i(miss_req), .miss_addr_i(miss_addr), .miss_req_ready_o(ready),
        .miss_addr_fifo_full_i(full), .miss_addr_fifo_wren_o(wren), .miss_addr_fifo_wdata_o(wdata),
        .mem_arvalid_o(arvalid), .mem_arready_i(arready), .mem_araddr_o(araddr),
        .mem_arlen_o(arlen), .mem_arsize_o(arsize), .mem_arburst_o(arburst),
        .mem_rvalid_i(rvalid), .mem_rready_i(rready), .mem_rlast_i(rlast),
        .outst_cnt_o(outst), .rd_err_o(rd_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input int n, input bit last_on_final);
        for (int i = 0; i < n; i++) begin
            rvalid = 1'b1; rready = 1'b1; rlast = last_on_final && (i == n - 1);
            step();
        end
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; miss_req = 1'b1; miss_addr = 32'h0000_0055; full = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        step(); step();
        n_cmp++;
        if (ready !== 1'b0 || wren !== 1'b0 || wdata !== 32'd0) begin
            n_bad++; $display("FAIL reset_comb: ready=%0b wren=%0b wdata=%h, want 0 0 0", ready, wren, wdata);
        end
        n_cmp++;
        if (arvalid !== 1'b0 || araddr !== 32'd0 || outst !== 3'd0 || rd_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_regs: arvalid=%0b araddr=%h outst=%0d rd_err=%0b, want 0 0 0 0", arvalid, araddr, outst, rd_err);
        end
        n_cmp++;
        if (arlen !== 4'd7 || arsize !== 3'b011 || arburst !== 2'b10) begin
            n_bad++; $display("FAIL const_ar: arlen=%0d arsize=%0d arburst=%0d, want 7 3 2", arlen, arsize, arburst);
        end
        rst = 1'b0; miss_req = 1'b0;
        step();
    endtask

    task automatic test_single_miss();
        miss_req = 1'b1; miss_addr = 32'h0000_1234; arready = 1'b1;
        #1;
        n_cmp++;
        if (ready !== 1'b1 || wren !== 1'b1 || wdata !== 32'h0000_1234) begin
            n_bad++; $display("FAIL single_push: ready=%0b wren=%0b wdata=%h, want 1 1 00001234", ready, wren, wdata);
        end
        step();
        miss_req = 1'b0;
        #1;
        n_cmp++;
        if (arvalid !== 1'b1 || araddr !== 32'h0000_1230 || arlen !== 4'd7 || arburst !== 2'd2 || outst !== 3'd1) begin
            n_bad++; $display("FAIL single_ar: arvalid=%0b araddr=%h arlen=%0d arburst=%0d outst=%0d, want 1 00001230 7 2 1", arvalid, araddr, arlen, arburst, outst);
        end
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++; $display("FAIL single_issue_ready: ready=%0b, want 0", ready);
        end
        step();
        n_cmp++;
        if (arvalid !== 1'b0) begin
            n_bad++; $display("FAIL single_ar_done: arvalid=%0b, want 0", arvalid);
        end
        send_beats(7, 1'b0);
        n_cmp++;
        if (outst !== 3'd1) begin
            n_bad++; $display("FAIL single_mid_burst: outst=%0d, want 1", outst);
        end
        send_beats(1, 1'b1);
        n_cmp++;
        if (outst !== 3'd0 || rd_err !== 1'b0) begin
            n_bad++; $display("FAIL single_retire: outst=%0d rd_err=%0b, want 0 0", outst, rd_err);
        end
    endtask

    task automatic test_throttle();
        logic [31:0] addrs [3];
        int acc_cyc[$];
        int acc2[$];
        int nacc = 0;
        int max_cnt = 0;
        addrs[0] = 32'h0000_0100; addrs[1] = 32'h0000_0240; addrs[2] = 32'h0000_0388;
        arready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            miss_req = 1'b1; miss_addr = addrs[(nacc > 2) ? 2 : nacc];
            #1;
            if (wren === 1'b1) begin acc_cyc.push_back(c); nacc++; end
            step();
            if (int'(outst) > max_cnt) max_cnt = int'(outst);
        end
        n_cmp++;
        if (acc_cyc.size() != 2) begin
            n_bad++; $display("FAIL throttle_first: accepts=%0d, want 2", acc_cyc.size());
        end else if (acc_cyc[0] != 0 || acc_cyc[1] != 2) begin
            n_bad++; $display("FAIL throttle_spacing: cycles=%0d,%0d, want 0,2", acc_cyc[0], acc_cyc[1]);
        end
        for (int c = 0; c < 11; c++) begin
            miss_req = (nacc < 3); miss_addr = addrs[2];
            rvalid = (c < 8); rready = (c < 8); rlast = (c == 7);
            #1;
            if (wren === 1'b1) begin acc2.push_back(c); nacc++; end
            step();
            if (int'(outst) > max_cnt) max_cnt = int'(outst);
        end
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; miss_req = 1'b0;
        n_cmp++;
        if (acc2.size() != 1) begin
            n_bad++; $display("FAIL throttle_third: accepts=%0d, want 1", acc2.size());
        end else if (acc2[0] != 8) begin
            n_bad++; $display("FAIL throttle_third_cycle: cycle=%0d, want 8", acc2[0]);
        end
        n_cmp++;
        if (max_cnt != 2 || outst !== 3'd2) begin
            n_bad++; $display("FAIL throttle_cnt: max=%0d outst=%0d, want 2 2", max_cnt, outst);
        end
        send_beats(8, 1'b1);
        send_beats(8, 1'b1);
        n_cmp++;
        if (outst !== 3'd0) begin
            n_bad++; $display("FAIL throttle_drain: outst=%0d, want 0", outst);
        end
    endtask

    task automatic test_ar_backpressure();
        int pushes = 0;
        bit stable = 1'b1;
        bit rdy_low = 1'b1;
        arready = 1'b0; miss_req = 1'b1; miss_addr = 32'hABCD_EF07;
        #1;
        if (wren === 1'b1) pushes++;
        step();
        miss_addr = 32'h0000_5000;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) begin arready = 1'b1; miss_req = 1'b0; end
            #1;
            if (arvalid !== 1'b1 || araddr !== 32'hABCD_EF00) stable = 1'b0;
            if (ready !== 1'b0) rdy_low = 1'b0;
            if (wren === 1'b1) pushes++;
            step();
        end
        n_cmp++;
        if (!stable || !rdy_low) begin
            n_bad++; $display("FAIL backpressure_hold: stable=%0b ready_low=%0b, want 1 1", stable, rdy_low);
        end
        n_cmp++;
        if (pushes != 1 || arvalid !== 1'b0) begin
            n_bad++; $display("FAIL backpressure_push: pushes=%0d arvalid=%0b, want 1 0", pushes, arvalid);
        end
        send_beats(8, 1'b1);
    endtask

    task automatic test_fifo_full();
        bit blocked = 1'b1;
        full = 1'b1; miss_req = 1'b1; miss_addr = 32'h0000_0F18; arready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (ready !== 1'b0 || wren !== 1'b0 || wdata !== 32'd0) blocked = 1'b0;
            step();
        end
        n_cmp++;
        if (!blocked || outst !== 3'd0) begin
            n_bad++; $display("FAIL full_block: blocked=%0b outst=%0d, want 1 0", blocked, outst);
        end
        full = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b1 || wren !== 1'b1 || wdata !== 32'h0000_0F18) begin
            n_bad++; $display("FAIL full_release: ready=%0b wren=%0b wdata=%h, want 1 1 00000f18", ready, wren, wdata);
        end
        step();
        miss_req = 1'b0;
        n_cmp++;
        if (outst !== 3'd1 || arvalid !== 1'b1 || araddr !== 32'h0000_0F18) begin
            n_bad++; $display("FAIL full_ar: outst=%0d arvalid=%0b araddr=%h, want 1 1 00000f18", outst, arvalid, araddr);
        end
        step();
    endtask

    task automatic test_simultaneous();
        send_beats(7, 1'b0);
        miss_req = 1'b1; miss_addr = 32'h0000_2000;
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        #1;
        n_cmp++;
        if (wren !== 1'b1) begin
            n_bad++; $display("FAIL simul_accept: wren=%0b, want 1", wren);
        end
        step();
        miss_req = 1'b0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        n_cmp++;
        if (outst !== 3'd1) begin
            n_bad++; $display("FAIL simul_cnt: outst=%0d, want 1", outst);
        end
        step();
        send_beats(8, 1'b1);
        n_cmp++;
        if (outst !== 3'd0 || rd_err !== 1'b0) begin
            n_bad++; $display("FAIL simul_drain: outst=%0d rd_err=%0b, want 0 0", outst, rd_err);
        end
    endtask

    task automatic test_rd_err();
        bit sticky = 1'b1;
        arready = 1'b1; miss_req = 1'b1; miss_addr = 32'h0000_3000;
        step();
        miss_req = 1'b0;
        step();
        send_beats(3, 1'b0);
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        #1;
        n_cmp++;
        if (rd_err !== 1'b0) begin
            n_bad++; $display("FAIL rd_err_early: rd_err=%0b, want 0", rd_err);
        end
        step();
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        n_cmp++;
        if (rd_err !== ERR_EN) begin
            n_bad++; $display("FAIL rd_err_set: rd_err=%0b, want %0b", rd_err, ERR_EN);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            if (rd_err !== ERR_EN) sticky = 1'b0;
        end
        n_cmp++;
        if (!sticky) begin
            n_bad++; $display("FAIL rd_err_sticky: rd_err=%0b, want %0b", rd_err, ERR_EN);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (rd_err !== 1'b0) begin
            n_bad++; $display("FAIL rd_err_clear: rd_err=%0b, want 0", rd_err);
        end
    endtask

    task automatic test_reset_mid();
        arready = 1'b0; miss_req = 1'b1; miss_addr = 32'h0000_4444;
        step();
        n_cmp++;
        if (arvalid !== 1'b1 || outst !== 3'd1) begin
            n_bad++; $display("FAIL mid_setup: arvalid=%0b outst=%0d, want 1 1", arvalid, outst);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ready !== 1'b0 || wren !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_comb: ready=%0b wren=%0b, want 0 0", ready, wren);
        end
        step();
        rst = 1'b0; miss_req = 1'b0;
        #1;
        n_cmp++;
        if (arvalid !== 1'b0 || outst !== 3'd0 || araddr !== 32'd0 || ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_rst_regs: arvalid=%0b outst=%0d araddr=%h ready=%0b, want 0 0 0 1", arvalid, outst, araddr, ready);
        end
    endtask

    task automatic test_random();
        bit          busy = 1'b0;
        bit          req_v = 1'b0;
        bit          exp_rdy;
        bit          acc;
        int          cnt = 0;
        int          beat = 0;
        logic [31:0] m_araddr = 32'd0;
        logic [31:0] req_a = 32'd0;
        logic [31:0] exp_wdata;
        for (int c = 0; c < 400; c++) begin
            n_cmp++;
            if (arvalid !== busy || araddr !== m_araddr || outst !== 3'(cnt) || rd_err !== 1'b0) begin
                n_bad++; $display("FAIL rand_regs[%0d]: arvalid=%0b araddr=%h outst=%0d rd_err=%0b, want %0b %h %0d 0", c, arvalid, araddr, outst, rd_err, busy, m_araddr, cnt);
            end
            if (!req_v && $urandom_range(0, 2) == 0) begin
                req_v = 1'b1; req_a = $urandom;
            end
            miss_req  = req_v;
            miss_addr = req_v ? req_a : $urandom;
            full      = ($urandom_range(0, 3) == 0);
            arready   = 1'($urandom_range(0, 1));
            rvalid    = (cnt > 0) && ($urandom_range(0, 1) == 1);
            rready    = 1'($urandom_range(0, 1));
            rlast     = rvalid && (beat == 7);
            #1;
            exp_rdy   = !busy && (cnt < MAX_OUTST) && !full;
            acc       = req_v && exp_rdy;
            exp_wdata = acc ? req_a : 32'd0;
            n_cmp++;
            if (ready !== exp_rdy || wren !== acc || wdata !== exp_wdata) begin
                n_bad++; $display("FAIL rand_push[%0d]: ready=%0b wren=%0b wdata=%h, want %0b %0b %h", c, ready, wren, wdata, exp_rdy, acc, exp_wdata);
            end
            if (busy && arready) busy = 1'b0;
            if (acc) begin
                busy = 1'b1; m_araddr = {req_a[31:3], 3'b000}; req_v = 1'b0; cnt++;
            end
            if (rvalid && rready) begin
                if (beat == 7) begin beat = 0; cnt--; end
                else beat++;
            end
            step();
        end
        miss_req = 1'b0; full = 1'b0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_throttle();
        test_ar_backpressure();
        test_fifo_full();
        test_simultaneous();
        test_rd_err();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
